sram_space_tracker: RTL and testbench



---
 rtl/sram_space_tracker_if.sv | 16 +
 rtl/sram_space_tracker.sv | 114 +++++++++++
 tb/tb_sram_space_tracker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_space_tracker_if.sv
// System clock/reset bundle for the shared-cache SRAM bookkeeping blocks.
// The master drives clock and active-low reset; slaves only observe them.
interface system_if;
    logic clk;
    logic rst;

    modport master (
        output clk,
        output rst
    );

    modport slave (
        input clk,
        input rst
    );
endinterface

// File: rtl/sram_space_tracker.sv
// Per-bank free-page counters for the 32 shared SRAM banks, with
// forwarded query lanes, empty flags, running total and sticky errors.
module sram_space_tracker #(
    parameter int NUM_SRAM  = 32,
    parameter int IDX_W     = 5,
    parameter int SPACE_W   = 11,
    parameter int MAX_SPACE = 2047,
    parameter int NUM_QUERY = 4,
    parameter int TOTAL_W   = 16
) (
    system_if.slave                       sys_if,
    input  logic                          alloc_valid,
    input  logic [IDX_W-1:0]              alloc_sram,
    output logic                          alloc_ready,
    input  logic                          free_valid,
    input  logic [IDX_W-1:0]              free_sram,
    input  logic [NUM_QUERY*IDX_W-1:0]    query_sram,
    output logic [NUM_QUERY*SPACE_W-1:0]  query_space,
    output logic [NUM_SRAM-1:0]           space_empty,
    output logic [TOTAL_W-1:0]            total_space,
    output logic                          alloc_err,
    output logic                          free_err,
    input  logic                          err_clr
);

    localparam logic [SPACE_W-1:0] MAX_V   = SPACE_W'(MAX_SPACE);
    localparam logic [TOTAL_W-1:0] TOTAL_V = TOTAL_W'(NUM_SRAM * MAX_SPACE);

    logic [SPACE_W-1:0]           r_space [NUM_SRAM];
    logic [SPACE_W-1:0]           w_next  [NUM_SRAM];
    logic [NUM_QUERY*SPACE_W-1:0] r_query;
    logic [NUM_SRAM-1:0]          r_empty;
    logic [TOTAL_W-1:0]           r_total;
    logic                         r_alloc_err;
    logic                         r_free_err;

    logic w_alloc_ready;
    logic w_alloc_acc;
    logic w_same_bank;
    logic w_free_eff;
    logic w_alloc_err_set;
    logic w_free_err_set;

    // Accept/drop decisions; a same-bank alloc+free nets to zero so the
    // release is effective even when the bank is full.
    always_comb begin
        w_alloc_ready   = (r_space[alloc_sram] != '0);
        w_alloc_acc     = alloc_valid & w_alloc_ready;
        w_same_bank     = w_alloc_acc & free_valid & (alloc_sram == free_sram);
        w_free_eff      = free_valid & (w_same_bank | (r_space[free_sram] != MAX_V));
        w_alloc_err_set = alloc_valid & ~w_alloc_ready;
        w_free_err_set  = free_valid & ~w_free_eff;
    end

    // Next-state counters, also used to forward fresh values to the queries.
    always_comb begin
        for (int i = 0; i < NUM_SRAM; i++) begin
            w_next[i] = r_space[i];
            if (w_alloc_acc && (alloc_sram == IDX_W'(i)))
                w_next[i] = w_next[i] - SPACE_W'(1);
            if (w_free_eff && (free_sram == IDX_W'(i)))
                w_next[i] = w_next[i] + SPACE_W'(1);
        end
    end

    // Counter storage, empty flags and forwarded query registers.
    always_ff @(posedge sys_if.clk) begin
        if (!sys_if.rst) begin
            for (int i = 0; i < NUM_SRAM; i++)
                r_space[i] <= MAX_V;
            for (int k = 0; k < NUM_QUERY; k++)
                r_query[k*SPACE_W +: SPACE_W] <= MAX_V;
            r_empty <= '0;
        end else begin
            for (int i = 0; i < NUM_SRAM; i++) begin
                r_space[i] <= w_next[i];
                r_empty[i] <= (w_next[i] == '0);
            end
            for (int k = 0; k < NUM_QUERY; k++)
                r_query[k*SPACE_W +: SPACE_W] <=
                    w_next[query_sram[k*IDX_W +: IDX_W]];
        end
    end

    // Running total kept incrementally from the accepted events.
    always_ff @(posedge sys_if.clk) begin
        if (!sys_if.rst)
            r_total <= TOTAL_V;
        else
            r_total <= r_total + TOTAL_W'(w_free_eff) - TOTAL_W'(w_alloc_acc);
    end

    // Sticky error flags; clear has priority over a same-cycle set.
    always_ff @(posedge sys_if.clk) begin
        if (!sys_if.rst) begin
            r_alloc_err <= 1'b0;
            r_free_err  <= 1'b0;
        end else if (err_clr) begin
            r_alloc_err <= 1'b0;
            r_free_err  <= 1'b0;
        end else begin
            r_alloc_err <= r_alloc_err | w_alloc_err_set;
            r_free_err  <= r_free_err | w_free_err_set;
        end
    end

    assign alloc_ready = w_alloc_ready;
    assign query_space = r_query;
    assign space_empty = r_empty;
    assign total_space = r_total;
    assign alloc_err   = r_alloc_err;
    assign free_err    = r_free_err;

endmodule

// File: tb/tb_sram_space_tracker.sv
// Randomized and directed bench for sram_space_tracker against a
// page-count model kept as a plain integer array.
module tb_sram_space_tracker;

    system_if sys_if ();

    logic        alloc_valid;
    logic [4:0]  alloc_sram;
    logic        alloc_ready;
    logic        free_valid;
    logic [4:0]  free_sram;
    logic [19:0] query_sram;
    logic [43:0] query_space;
    logic [31:0] space_empty;
    logic [15:0] total_space;
    logic        alloc_err;
    logic        free_err;
    logic        err_clr;

    sram_space_tracker dut (
        .sys_if      (sys_if.slave),
        .alloc_valid (alloc_valid),
        .alloc_sram  (alloc_sram),
        .alloc_ready (alloc_ready),
        .free_valid  (free_valid),
        .free_sram   (free_sram),
        .query_sram  (query_sram),
        .query_space (query_space),
        .space_empty (space_empty),
        .total_space (total_space),
        .alloc_err   (alloc_err),
        .free_err    (free_err),
        .err_clr     (err_clr)
    );

    int n_chk = 0;
    int n_err = 0;

    int m_space [32];
    bit m_aerr;
    bit m_ferr;

    initial sys_if.clk = 1'b0;
    always #5 sys_if.clk = ~sys_if.clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_space[i] = 2047;
        m_aerr = 0;
        m_ferr = 0;
    endtask

    task automatic check_state(input logic [19:0] q);
        int          sum;
        logic [31:0] emp;
        sum = 0;
        emp = '0;
        for (int i = 0; i < 32; i++) begin
            sum += m_space[i];
            emp[i] = (m_space[i] == 0);
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("lane%0d", k), 32'(query_space[k*11 +: 11]),
                  32'(m_space[q[k*5 +: 5]]));
        check("total", 32'(total_space), 32'(sum));
        check("empty", space_empty, emp);
        check("alloc_err", 32'(alloc_err), 32'(m_aerr));
        check("free_err", 32'(free_err), 32'(m_ferr));
    endtask

    task automatic step(input logic av, input logic [4:0] as,
                        input logic fv, input logic [4:0] fs,
                        input logic clr, input logic [19:0] q);
        bit rdy;
        bit acc;
        alloc_valid = av;
        alloc_sram  = as;
        free_valid  = fv;
        free_sram   = fs;
        err_clr     = clr;
        query_sram  = q;
        #1;
        rdy = (m_space[as] != 0);
        check("alloc_ready", 32'(alloc_ready), 32'(rdy));
        acc = av && rdy;
        if (av && !rdy) m_aerr = 1;
        if (fv) begin
            if (acc && as == fs) begin
            end else if (m_space[fs] < 2047) m_space[fs]++;
            else m_ferr = 1;
        end
        if (acc && !(fv && as == fs)) m_space[as]--;
        if (clr) begin
            m_aerr = 0;
            m_ferr = 0;
        end
        @(posedge sys_if.clk);
        #1;
        check_state(q);
    endtask

    task automatic do_reset(input int cycles, input logic av);
        sys_if.rst  = 1'b0;
        alloc_valid = av;
        alloc_sram  = 5'($urandom_range(31));
        free_valid  = av;
        free_sram   = 5'($urandom_range(31));
        err_clr     = 1'b0;
        query_sram  = 20'($urandom);
        repeat (cycles) @(posedge sys_if.clk);
        #1;
        sys_if.rst  = 1'b1;
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
        model_reset();
        check_state(query_sram);
    endtask

    function automatic logic [19:0] rq();
        return 20'($urandom);
    endfunction

    initial begin
        sys_if.rst  = 1'b0;
        alloc_valid = 1'b0;
        alloc_sram  = '0;
        free_valid  = 1'b0;
        free_sram   = '0;
        err_clr     = 1'b0;
        query_sram  = '0;
        model_reset();

        do_reset(2, 1'b0);
        check("rst_total", 32'(total_space), 32'd65504);
        check("rst_lane0", 32'(query_space[10:0]), 32'd2047);
        alloc_sram = 5'd9;
        #1;
        check("rst_ready", 32'(alloc_ready), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(1, 5'd7, 0, 5'd0, 0, {15'd0, 5'd7});
            check("fwd_lane0", 32'(query_space[10:0]), 32'(2046 - i));
        end
        check("fwd_total", 32'(total_space), 32'd65501);

        do_reset(1, 1'b0);
        for (int i = 0; i < 2047; i++)
            step(1, 5'd3, 0, 5'd0, 0, {15'd0, 5'd3});
        check("drain_empty3", 32'(space_empty[3]), 32'd1);
        alloc_sram = 5'd3;
        #1;
        check("drain_ready3", 32'(alloc_ready), 32'd0);
        step(1, 5'd3, 0, 5'd0, 0, {15'd0, 5'd3});
        check("drain_cnt3", 32'(query_space[10:0]), 32'd0);
        check("drain_aerr", 32'(alloc_err), 32'd1);
        step(0, 5'd3, 0, 5'd0, 1, {15'd0, 5'd3});
        check("clr_aerr", 32'(alloc_err), 32'd0);
        step(1, 5'd3, 1, 5'd3, 0, {15'd0, 5'd3});
        check("zero_same_cnt", 32'(query_space[10:0]), 32'd1);
        check("zero_same_aerr", 32'(alloc_err), 32'd1);
        step(1, 5'd3, 0, 5'd0, 1, {15'd0, 5'd3});
        check("clr_wins", 32'(alloc_err), 32'd0);

        do_reset(1, 1'b0);
        step(0, 5'd0, 1, 5'd12, 0, {15'd0, 5'd12});
        check("ovf_cnt", 32'(query_space[10:0]), 32'd2047);
        check("ovf_ferr", 32'(free_err), 32'd1);
        check("ovf_total", 32'(total_space), 32'd65504);

        do_reset(1, 1'b0);
        step(1, 5'd5, 1, 5'd5, 0, {15'd0, 5'd5});
        check("same_cnt", 32'(query_space[10:0]), 32'd2047);
        check("same_ferr", 32'(free_err), 32'd0);
        check("same_aerr", 32'(alloc_err), 32'd0);

        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1, 5'd31, 0, 5'd0, 0, rq());
        step(1, 5'd0, 1, 5'd31, 0, {10'd0, 5'd31, 5'd0});
        check("diff_b0", 32'(query_space[10:0]), 32'd2046);
        check("diff_b31", 32'(query_space[21:11]), 32'd2038);
        check("diff_total", 32'(total_space), 32'd65494);

        do_reset(1, 1'b0);
        for (int i = 0; i < 100; i++)
            step(1'($urandom), 5'($urandom), 1'($urandom),
                 5'($urandom), ($urandom_range(15) == 0), rq());
        do_reset(1, 1'b1);
        check("mid_total", 32'(total_space), 32'd65504);
        check("mid_aerr", 32'(alloc_err), 32'd0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom), 5'($urandom_range(3)), 1'($urandom),
                 5'($urandom_range(3)), ($urandom_range(31) == 0),
                 {5'($urandom_range(3)), 5'($urandom_range(3)),
                  5'($urandom_range(3)), 5'($urandom_range(3))});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
